lsu_mem_stage: RTL and testbench

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_mem_stage_if.sv | 42 ++++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu_mem_stage.sv | 151 +++++++++++++++
 tb/tb_lsu_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory stage: funct3 encodings, FSM state type,
// default bus-wait budget and small decode helpers.
package lsu_pkg;

    localparam int WAIT_TIMEOUT_DEFAULT = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Stores have no unsigned variants, so they accept a narrower funct3 set than loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        if (is_store)
            return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic [1:0] natural_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return off;
            2'b01:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Signal bundle between the LSU memory stage and its surroundings (EX stage,
// data memory, writeback); slave is the LSU side, master the environment side.
interface lsu_mem_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rs2_data;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_fault;
    logic [31:0] fault_addr;

    modport master (
        output ex_valid, ex_alu_out, ex_rs2_data, ex_funct3, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               wb_valid, wb_reg_write, wb_rd, wb_data, mem_fault, fault_addr
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_rs2_data, ex_funct3, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               wb_valid, wb_reg_write, wb_rd, wb_data, mem_fault, fault_addr
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store-lane replication for the
// outgoing access, byte/half extraction and extension for returning load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);
    logic [31:0] w_shifted;

    // Replicating into every lane lets the byte enables alone pick the target bytes.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_size)
            2'b00: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_st_off;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   o_ld_data = {24'h0, w_shifted[7:0]};
            F3_HU:   o_ld_data = {16'h0, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory stage: accepts one EX op at a time, runs a single data-memory access
// with a bounded wait, and emits a one-cycle writeback or fault pulse.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses
// instead of silently aligning them.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    lsu_mem_stage_if.slave lsu
);
    localparam int CW = $clog2(WAIT_TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;

    logic [31:0] r_addr, r_wdata, r_faddr, r_wb_data, r_fault_addr;
    logic [3:0]  r_be;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [4:0]  r_rd, r_wb_rd;
    logic        r_we, r_reg_write, r_wb_valid, r_wb_reg_write, r_mem_fault;

    logic        w_accept, w_is_mem, w_misalign, w_fault_req, w_start;
    logic        w_ack, w_last, w_timeout;
    logic [1:0]  w_off;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;

    assign w_accept    = lsu.ex_valid && (r_state == IDLE);
    assign w_is_mem    = lsu.ex_mem_read || lsu.ex_mem_write;
    assign w_off       = natural_off(lsu.ex_funct3, lsu.ex_alu_out[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign  = is_misaligned(lsu.ex_funct3, lsu.ex_alu_out[1:0]);
`else
    assign w_misalign  = 1'b0;
`endif
    assign w_fault_req = w_is_mem && ((lsu.ex_mem_read && lsu.ex_mem_write) ||
                         !f3_legal(lsu.ex_funct3, lsu.ex_mem_write) || w_misalign);
    assign w_start     = w_accept && w_is_mem && !w_fault_req;
    assign w_ack       = (r_state == BUSY) && lsu.dmem_ack;
    assign w_last      = (r_cnt == CW'(WAIT_TIMEOUT - 1));
    assign w_timeout   = (r_state == BUSY) && !lsu.dmem_ack && w_last;

    lsu_align u_align (
        .i_st_size   (lsu.ex_funct3[1:0]),
        .i_st_off    (w_off),
        .i_st_data   (lsu.ex_rs2_data),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_ld_rdata  (lsu.dmem_rdata),
        .o_ld_data   (w_load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // An ack on the final wait cycle still completes the access rather than faulting.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = BUSY;
            BUSY:    if (lsu.dmem_ack || w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        lsu.ex_ready = (r_state == IDLE);
        lsu.dmem_req = (r_state == BUSY);
        lsu.dmem_we  = (r_state == BUSY) && r_we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_be           <= '0;
            r_we           <= 1'b0;
            r_funct3       <= '0;
            r_off          <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_faddr        <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_mem_fault    <= 1'b0;
            r_fault_addr   <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_mem_fault <= 1'b0;
            if (r_state == BUSY && !lsu.dmem_ack && !w_last)
                r_cnt <= r_cnt + CW'(1);
            else
                r_cnt <= '0;
            if (w_start) begin
                r_addr      <= {lsu.ex_alu_out[31:2], 2'b00};
                r_wdata     <= w_wdata;
                r_be        <= w_be;
                r_we        <= lsu.ex_mem_write;
                r_funct3    <= lsu.ex_funct3;
                r_off       <= w_off;
                r_rd        <= lsu.ex_rd;
                r_reg_write <= lsu.ex_reg_write && !lsu.ex_mem_write;
                r_faddr     <= lsu.ex_alu_out;
            end
            if (w_accept && !w_is_mem) begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= lsu.ex_alu_out;
                r_wb_rd        <= lsu.ex_rd;
                r_wb_reg_write <= lsu.ex_reg_write;
            end
            if (w_accept && w_fault_req) begin
                r_mem_fault  <= 1'b1;
                r_fault_addr <= lsu.ex_alu_out;
            end
            if (w_ack) begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= r_we ? 32'h0 : w_load_data;
                r_wb_rd        <= r_rd;
                r_wb_reg_write <= r_reg_write;
            end
            if (w_timeout) begin
                r_mem_fault  <= 1'b1;
                r_fault_addr <= r_faddr;
            end
        end
    end

    assign lsu.dmem_addr    = r_addr;
    assign lsu.dmem_wdata   = r_wdata;
    assign lsu.dmem_be      = r_be;
    assign lsu.wb_valid     = r_wb_valid;
    assign lsu.wb_reg_write = r_wb_reg_write;
    assign lsu.wb_rd        = r_wb_rd;
    assign lsu.wb_data      = r_wb_data;
    assign lsu.mem_fault    = r_mem_fault;
    assign lsu.fault_addr   = r_fault_addr;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed cases plus randomized ops checked
// against a byte-level reference model; a monitor pops expectations on each output pulse.
module tb_lsu_mem_stage;
    localparam int WT = 64;

    typedef struct {
        bit          isFault;
        bit          chkData;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          regWrite;
        logic [31:0] faddr;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatch = 0;
    int   wbSeen = 0;
    exp_t expQ[$];
    exp_t monE;

    logic [31:0] lastWbData, lastFaultAddr, lastAddr, lastWdata;
    logic [4:0]  lastWbRd;
    logic        lastWbRegWrite;
    logic [3:0]  lastBe;

    lsu_mem_stage_if lsu();

    lsu_mem_stage #(.WAIT_TIMEOUT(WT)) dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (lsu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Little-endian byte view: pick the accessed bytes, then extend by value range.
    function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input int aoff,
                                              input int size, input bit isSigned);
        longint v, modulus;
        modulus = longint'(1) << (8 * size);
        v = longint'({32'h0, rdata});
        v = (v >> (8 * aoff)) % modulus;
        if (isSigned && v >= modulus / 2)
            v = v - modulus;
        return v[31:0];
    endfunction

    task automatic waitDrain();
        int guard = 0;
        while (expQ.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("queueDrain", 32'(expQ.size()), 32'd0);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] rs2,
                                 input logic [2:0] f3, input logic [4:0] rd, input bit regW,
                                 input bit memR, input bit memW, input int ackDelay,
                                 input logic [31:0] rdata);
        exp_t        e;
        int          size, off, aoff, guard;
        bit          isMem, legal, fault, trap;
        logic [3:0]  be;
        logic [31:0] wd, laneMask, t;
        guard = 0;
        @(negedge clk);
        while (lsu.ex_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("exReadyWait", 32'(lsu.ex_ready), 32'd1);

        isMem = memR || memW;
        size  = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        legal = memW ? (f3 inside {3'b000, 3'b001, 3'b010})
                     : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        off   = int'(addr % 32'd4);
        aoff  = off - (off % size);
`ifdef LSU_MISALIGN_TRAP_EN
        trap  = (off % size) != 0;
`else
        trap  = 1'b0;
`endif
        fault = isMem && ((memR && memW) || !legal || trap);
        be = 4'b0000; wd = '0; laneMask = '0;
        for (int j = 0; j < 4; j++) begin
            if (j >= aoff && j < aoff + size) begin
                be[j] = 1'b1;
                t = rs2 >> (8 * (j - aoff));
                wd[8*j +: 8] = t[7:0];
                laneMask[8*j +: 8] = 8'hFF;
            end
        end

        e = '{isFault: 1'b0, chkData: 1'b1, data: addr, rd: rd, regWrite: regW,
              faddr: addr, cyc: cyc + 1};
        if (isMem && fault) begin
            e.isFault = 1'b1;
        end else if (isMem && ackDelay >= 0 && ackDelay < WT) begin
            e.cyc      = cyc + 2 + ackDelay;
            e.chkData  = memR;
            e.data     = memR ? modelLoad(rdata, aoff, size, f3[2] == 1'b0) : 32'h0;
            e.regWrite = memW ? 1'b0 : regW;
        end else if (isMem) begin
            e.isFault = 1'b1;
            e.cyc     = cyc + 1 + WT;
        end
        expQ.push_back(e);

        lsu.ex_alu_out   = addr;
        lsu.ex_rs2_data  = rs2;
        lsu.ex_funct3    = f3;
        lsu.ex_rd        = rd;
        lsu.ex_reg_write = regW;
        lsu.ex_mem_read  = memR;
        lsu.ex_mem_write = memW;
        lsu.ex_valid     = 1'b1;
        @(negedge clk);
        lsu.ex_valid = 1'b0;

        if (!isMem || fault) begin
            checkOutput("noBusReq", 32'(lsu.dmem_req), 32'd0);
        end else begin
            lastAddr  = lsu.dmem_addr;
            lastBe    = lsu.dmem_be;
            lastWdata = lsu.dmem_wdata;
            checkOutput("busReq", 32'(lsu.dmem_req), 32'd1);
            checkOutput("busWe", 32'(lsu.dmem_we), 32'(memW));
            checkOutput("busAddr", lsu.dmem_addr, addr - 32'(off));
            checkOutput("busBe", 32'(lsu.dmem_be), 32'(be));
            if (memW) checkOutput("busWdata", lsu.dmem_wdata & laneMask, wd & laneMask);
            if (ackDelay >= 0 && ackDelay < WT) begin
                repeat (ackDelay) @(negedge clk);
                checkOutput("reqAtAck", 32'(lsu.dmem_req), 32'd1);
                lsu.dmem_ack   = 1'b1;
                lsu.dmem_rdata = rdata;
                @(negedge clk);
                lsu.dmem_ack   = 1'b0;
                lsu.dmem_rdata = $urandom;
            end else begin
                repeat (WT - 1) @(negedge clk);
                checkOutput("reqBeforeTimeout", 32'(lsu.dmem_req), 32'd1);
                @(negedge clk);
                checkOutput("reqDropped", 32'(lsu.dmem_req), 32'd0);
                checkOutput("readyAfterTimeout", 32'(lsu.ex_ready), 32'd1);
            end
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (lsu.wb_valid === 1'b1 || lsu.mem_fault === 1'b1)) begin
            if (lsu.wb_valid === 1'b1) wbSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedOutput", {30'h0, lsu.wb_valid, lsu.mem_fault}, 32'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("outCycle", 32'(cyc), 32'(monE.cyc));
                checkOutput("memFault", 32'(lsu.mem_fault), 32'(monE.isFault));
                checkOutput("wbValid", 32'(lsu.wb_valid), 32'(!monE.isFault));
                if (monE.isFault) begin
                    lastFaultAddr = lsu.fault_addr;
                    checkOutput("faultAddr", lsu.fault_addr, monE.faddr);
                end else begin
                    lastWbData     = lsu.wb_data;
                    lastWbRd       = lsu.wb_rd;
                    lastWbRegWrite = lsu.wb_reg_write;
                    checkOutput("wbRegWrite", 32'(lsu.wb_reg_write), 32'(monE.regWrite));
                    if (monE.chkData) begin
                        checkOutput("wbData", lsu.wb_data, monE.data);
                        checkOutput("wbRd", 32'(lsu.wb_rd), 32'(monE.rd));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        checkOutput("watchdog", 32'd0, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        logic [2:0] ldF3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] badLdF3[3] = '{3'b011, 3'b110, 3'b111};
        int seen, kind;
        reset = 1'b1;
        lsu.ex_valid = 1'b0; lsu.ex_alu_out = '0; lsu.ex_rs2_data = '0; lsu.ex_funct3 = '0;
        lsu.ex_rd = '0; lsu.ex_reg_write = 1'b0; lsu.ex_mem_read = 1'b0; lsu.ex_mem_write = 1'b0;
        lsu.dmem_ack = 1'b0; lsu.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstExReady", 32'(lsu.ex_ready), 32'd1);
        checkOutput("rstDmemReq", 32'(lsu.dmem_req), 32'd0);
        checkOutput("rstWbValid", 32'(lsu.wb_valid), 32'd0);
        checkOutput("rstMemFault", 32'(lsu.mem_fault), 32'd0);
        checkOutput("rstWbData", lsu.wb_data, 32'd0);
        checkOutput("rstFaultAddr", lsu.fault_addr, 32'd0);
        checkOutput("rstDmemAddr", lsu.dmem_addr, 32'd0);
        checkOutput("rstDmemBe", 32'(lsu.dmem_be), 32'd0);
        reset = 1'b0;
        $display("[TB] reset released");

        seen = wbSeen;
        lsu.dmem_ack = 1'b1; lsu.dmem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        lsu.dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idleAckIgnored", 32'(wbSeen - seen), 32'd0);

        applyStimulus(32'h0000_1234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        waitDrain();
        checkOutput("aluWbData", lastWbData, 32'h0000_1234);
        checkOutput("aluWbRd", 32'(lastWbRd), 32'd5);

        applyStimulus(32'h0000_0103, 32'h0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0, 3, 32'h80FF_FF7F);
        waitDrain();
        checkOutput("lbAddr", lastAddr, 32'h0000_0100);
        checkOutput("lbBe", 32'(lastBe), 32'h8);
        checkOutput("lbData", lastWbData, 32'hFFFF_FF80);

        applyStimulus(32'h0000_0202, 32'h0000_ABCD, 3'b001, 5'd9, 1'b1, 1'b0, 1'b1, 0, 32'h0);
        waitDrain();
        checkOutput("shBe", 32'(lastBe), 32'hC);
        checkOutput("shWdataHi", {16'h0, lastWdata[31:16]}, 32'h0000_ABCD);
        checkOutput("shRegWrite", 32'(lastWbRegWrite), 32'd0);

        applyStimulus(32'h0000_0301, 32'h0, 3'b010, 5'd3, 1'b1, 1'b1, 1'b0, 1, 32'h1122_3344);
        waitDrain();
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("lwMisalignFault", lastFaultAddr, 32'h0000_0301);
`else
        checkOutput("lwMisalignAddr", lastAddr, 32'h0000_0300);
`endif

        applyStimulus(32'h0000_0500, 32'h0, 3'b010, 5'd4, 1'b1, 1'b1, 1'b0, -1, 32'h0);
        waitDrain();
        checkOutput("timeoutFaultAddr", lastFaultAddr, 32'h0000_0500);

        @(negedge clk);
        lsu.ex_alu_out = 32'h0000_0400; lsu.ex_funct3 = 3'b010; lsu.ex_rd = 5'd2;
        lsu.ex_reg_write = 1'b1; lsu.ex_mem_read = 1'b1; lsu.ex_mem_write = 1'b0;
        lsu.ex_valid = 1'b1;
        @(negedge clk);
        lsu.ex_valid = 1'b0;
        checkOutput("midBusyReq", 32'(lsu.dmem_req), 32'd1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRstReq", 32'(lsu.dmem_req), 32'd0);
        checkOutput("asyncRstReady", 32'(lsu.ex_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = wbSeen;
        lsu.dmem_ack = 1'b1; lsu.dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        lsu.dmem_ack = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("ackAfterReset", 32'(wbSeen - seen), 32'd0);

        for (int n = 0; n < 160; n++) begin
            logic [31:0] addr, rs2, rdata;
            logic [2:0]  f3;
            bit          memR, memW;
            addr  = $urandom; rs2 = $urandom; rdata = $urandom;
            kind  = int'($urandom_range(0, 9));
            memR  = 1'b0; memW = 1'b0;
            f3    = 3'($urandom_range(0, 7));
            if (kind >= 3 && kind <= 5) begin
                memR = 1'b1; f3 = ldF3[$urandom_range(0, 4)];
            end else if (kind == 6 || kind == 7) begin
                memW = 1'b1; f3 = 3'($urandom_range(0, 2));
            end else if (kind == 8) begin
                if ($urandom_range(0, 1) == 1) begin
                    memR = 1'b1; f3 = badLdF3[$urandom_range(0, 2)];
                end else begin
                    memW = 1'b1; f3 = 3'($urandom_range(3, 7));
                end
            end else if (kind == 9) begin
                memR = 1'b1; memW = 1'b1;
            end
            applyStimulus(addr, rs2, f3, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          memR, memW, int'($urandom_range(0, 4)), rdata);
        end
        waitDrain();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
